stage_memory_param: RTL and testbench

STAGE_MEMORY_PARAM -- requirements
Module: stage_memory_param

---
 rtl/stage_memory_param.sv | 148 ++++++++++++++
 tb/tb_stage_memory_param.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_memory_param.sv
// -----------------------------------------------------------------------------
// stage_memory_param
//
// Memory stage of a simple in-order pipeline. It holds a word-addressed data
// memory with byte-lane store enables, a one-entry result register facing
// write-back with a valid/ready handshake, and a second read port that feeds
// instruction fetch every cycle.
//
// Optional feature macro: STAGE_MEM_PERF_EN
//   defined   -> load/store/stall performance counters are live (saturating)
//   undefined -> counter ports are tied to zero
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   instr_type               instruction class; LOAD_TYPE / STORE_TYPE decoded
//   mem_addr                 word address; only the low ADDR_W bits are used
//   store_data, store_strb   store data and per-byte write enables
//   alu_result               execute result, forwarded for non-loads
//   ireg_in                  instruction register carried down the pipe
//   fetch_addr, fetch_data   fetch read port, registered every edge
//   out_valid / out_ready    write-back handshake
//   out_result, out_ireg     write-back payload
//   load_count, store_count, stall_count   performance counters
// -----------------------------------------------------------------------------
module stage_memory_param #(
    parameter int         DATA_W     = 32,
    parameter int         DEPTH      = 2048,
    parameter logic [4:0] LOAD_TYPE  = 5'd3,
    parameter logic [4:0] STORE_TYPE = 5'd4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          instr_type,
    input  logic [31:0]         mem_addr,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [DATA_W/8-1:0] store_strb,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [31:0]         ireg_in,
    input  logic [31:0]         fetch_addr,
    output logic [DATA_W-1:0]   fetch_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_result,
    output logic [31:0]         out_ireg,
    output logic [31:0]         load_count,
    output logic [31:0]         store_count,
    output logic [31:0]         stall_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NBYTES = DATA_W / 8;

    // Not reset: contents survive rst by design.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] fidx;
    logic              accept;
    logic              is_load;
    logic              is_store;
    logic              wr_en;

    // Upper address bits alias onto the same words; they are intentionally
    // dropped here.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W], fetch_addr[31:ADDR_W]};

    assign idx      = mem_addr[ADDR_W-1:0];
    assign fidx     = fetch_addr[ADDR_W-1:0];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_load  = (instr_type == LOAD_TYPE);
    assign is_store = (instr_type == STORE_TYPE);
    // rst gates the write so a store presented during reset is dropped.
    assign wr_en    = accept && is_store && !rst;

    // Byte-lane write. Reads elsewhere see pre-write contents on the same
    // edge, which gives load/fetch their read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (store_strb[b]) begin
                    mem[idx][b*8 +: 8] <= store_data[b*8 +: 8];
                end
            end
        end
    end

    // Result register towards write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ireg   <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= is_load ? mem[idx] : alu_result;
            out_ireg   <= ireg_in;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Fetch port runs every cycle regardless of the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_data <= '0;
        end else begin
            fetch_data <= mem[fidx];
        end
    end

`ifdef STAGE_MEM_PERF_EN
    logic load_acc;
    logic store_acc;
    logic stalled;

    assign load_acc  = accept && is_load;
    assign store_acc = accept && is_store;
    assign stalled   = out_valid && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_count  <= '0;
            store_count <= '0;
            stall_count <= '0;
        end else begin
            if (load_acc && load_count != 32'hFFFF_FFFF) begin
                load_count <= load_count + 32'd1;
            end
            if (store_acc && store_count != 32'hFFFF_FFFF) begin
                store_count <= store_count + 32'd1;
            end
            if (stalled && stall_count != 32'hFFFF_FFFF) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`else
    assign load_count  = '0;
    assign store_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_stage_memory_param.sv
// -----------------------------------------------------------------------------
// tb_stage_memory_param
//
// Bench for stage_memory_param with default parameters (DATA_W 32, DEPTH 2048).
// A directed vector table covers the store/load/aliasing/fetch cases, hand
// sequences cover stall and reset-during-stall, and a randomized phase is
// checked against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_stage_memory_param;

    localparam int         DATA_W = 32;
    localparam int         DEPTH  = 2048;
    localparam logic [4:0] LT     = 5'd3;
    localparam logic [4:0] ST     = 5'd4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  instr_type;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [3:0]  store_strb;
    logic [31:0] alu_result;
    logic [31:0] ireg_in;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_ireg;
    logic [31:0] load_count;
    logic [31:0] store_count;
    logic [31:0] stall_count;

    stage_memory_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LOAD_TYPE(LT), .STORE_TYPE(ST)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_type(instr_type), .mem_addr(mem_addr),
        .store_data(store_data), .store_strb(store_strb),
        .alu_result(alu_result), .ireg_in(ireg_in),
        .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ireg(out_ireg),
        .load_count(load_count), .store_count(store_count),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_counters(input string nm, input int l, input int s, input int st);
`ifdef STAGE_MEM_PERF_EN
        chk({nm, ".load_count"},  load_count,  32'(l));
        chk({nm, ".store_count"}, store_count, 32'(s));
        chk({nm, ".stall_count"}, stall_count, 32'(st));
`else
        chk({nm, ".load_count"},  load_count,  32'd0);
        chk({nm, ".store_count"}, store_count, 32'd0);
        chk({nm, ".stall_count"}, stall_count, 32'd0);
`endif
    endtask

    task automatic drive(input logic v, input logic [4:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [31:0] alu,
                         input logic [31:0] ir, input logic [31:0] fa, input logic rdy);
        in_valid   = v;
        instr_type = t;
        mem_addr   = a;
        store_data = d;
        store_strb = s;
        alu_result = alu;
        ireg_in    = ir;
        fetch_addr = fa;
        out_ready  = rdy;
    endtask

    typedef struct {
        logic        vld;
        logic [4:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] faddr;
        logic        ordy;
        logic        e_vld;
        logic [31:0] e_res;
        logic        f_chk;
        logic [31:0] e_fetch;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl [NVEC];

    // Behavioural model state for the random phase (indices 0..15 only).
    logic [31:0] mm [16];
    logic        mk [16];
    logic        m_valid;
    logic [31:0] m_res;
    logic        m_res_k;
    logic [31:0] m_ireg;
    logic [31:0] m_fetch;
    logic        m_fetch_k;
    int          m_lc, m_sc, m_stc;

    function automatic vec_t mk_vec(input logic v, input logic [4:0] t, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] s,
                                    input logic [31:0] fa, input logic r, input logic ev,
                                    input logic [31:0] er, input logic fc,
                                    input logic [31:0] ef);
        vec_t x;
        x.vld = v; x.typ = t; x.addr = a; x.data = d; x.strb = s; x.faddr = fa;
        x.ordy = r; x.e_vld = ev; x.e_res = er; x.f_chk = fc; x.e_fetch = ef;
        return x;
    endfunction

    initial begin
        logic [31:0] alu_i;
        logic [31:0] held_res;
        logic [31:0] held_ireg;

        // alu_result for row i is 32'hA000 + i; ireg for row i is 32'h100 + i.
        tbl[0]  = mk_vec(1, ST, 5,          32'hDEADBEEF, 4'hF, 5,          1, 1, 32'hA000, 0, 0);
        tbl[1]  = mk_vec(1, LT, 5,          0,            4'h0, 5,          1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        tbl[2]  = mk_vec(1, ST, 7,          32'h11223344, 4'hF, 7,          1, 1, 32'hA002, 0, 0);
        tbl[3]  = mk_vec(1, ST, 7,          32'h000000AA, 4'h1, 7,          1, 1, 32'hA003, 1, 32'h11223344);
        tbl[4]  = mk_vec(1, LT, 7,          0,            4'h0, 7,          1, 1, 32'h112233AA, 1, 32'h112233AA);
        tbl[5]  = mk_vec(1, ST, DEPTH + 3,  32'h00000055, 4'hF, 3,          1, 1, 32'hA005, 0, 0);
        tbl[6]  = mk_vec(1, LT, 3,          0,            4'h0, DEPTH + 3,  1, 1, 32'h00000055, 1, 32'h00000055);
        tbl[7]  = mk_vec(1, ST, 5,          32'h00000000, 4'h0, 5,          1, 1, 32'hA007, 1, 32'hDEADBEEF);
        tbl[8]  = mk_vec(0, ST, 5,          32'hFFFFFFFF, 4'hF, 5,          1, 0, 0,            1, 32'hDEADBEEF);
        tbl[9]  = mk_vec(1, LT, 5,          0,            4'h0, 5,          1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        tbl[10] = mk_vec(1, 5'd0, 5,        32'hFFFFFFFF, 4'hF, 5,          1, 1, 32'hA00A, 1, 32'hDEADBEEF);
        tbl[11] = mk_vec(1, ST, 9,          32'h12345678, 4'hF, 5,          1, 1, 32'hA00B, 1, 32'hDEADBEEF);
        tbl[12] = mk_vec(1, ST, 9,          32'h99999999, 4'hF, 9,          1, 1, 32'hA00C, 1, 32'h12345678);
        tbl[13] = mk_vec(0, 5'd0, 9,        0,            4'h0, 9,          1, 0, 0,            1, 32'h99999999);
        tbl[14] = mk_vec(1, LT, 9 + 4096,   0,            4'h0, 7,          1, 1, 32'h99999999, 1, 32'h112233AA);

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        @(negedge clk);
        chk("reset.out_valid",  {31'd0, out_valid}, 32'd0);
        chk("reset.out_result", out_result, 32'd0);
        chk("reset.out_ireg",   out_ireg,   32'd0);
        chk("reset.fetch_data", fetch_data, 32'd0);
        chk("reset.in_ready",   {31'd0, in_ready}, 32'd1);
        chk_counters("reset", 0, 0, 0);
        rst = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < NVEC; i++) begin
            alu_i = 32'hA000 + 32'(i);
            drive(tbl[i].vld, tbl[i].typ, tbl[i].addr, tbl[i].data, tbl[i].strb,
                  alu_i, 32'h100 + 32'(i), tbl[i].faddr, tbl[i].ordy);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d.out_result", i), out_result, tbl[i].e_res);
                chk($sformatf("vec%0d.out_ireg", i), out_ireg, 32'h100 + 32'(i));
            end
            if (tbl[i].f_chk) chk($sformatf("vec%0d.fetch_data", i), fetch_data, tbl[i].e_fetch);
        end
        chk_counters("table", 5, 7, 0);

        // ---------------- stall hold ----------------
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_counters("pulse", 0, 0, 0);
        drive(1, ST, 11, 32'hA5A5A5A5, 4'hF, 32'hBEE0, 32'h200, 11, 1);
        @(posedge clk);
        @(negedge clk);
        held_res  = out_result;
        held_ireg = out_ireg;
        chk("stall.accept_result", held_res, 32'hBEE0);
        drive(1, ST, 11, 32'hFFFFFFFF, 4'hF, 32'hBEE1, 32'h201, 11, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stall%0d.out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d.out_result", c), out_result, 32'hBEE0);
            chk($sformatf("stall%0d.out_ireg", c), out_ireg, 32'h200);
        end
        chk("stall.fetch_unchanged", fetch_data, 32'hA5A5A5A5);
        chk_counters("stall", 0, 1, 3);
        drive(1, LT, 11, 0, 0, 0, 32'h202, 11, 1);
        @(posedge clk);
        @(negedge clk);
        chk("stall.load_after", out_result, 32'hA5A5A5A5);

        // ---------------- reset during stall ----------------
        drive(0, 0, 0, 0, 0, 0, 0, 11, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rststall.pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rststall.out_valid",  {31'd0, out_valid}, 32'd0);
        chk("rststall.out_result", out_result, 32'd0);
        chk("rststall.out_ireg",   out_ireg,   32'd0);
        chk("rststall.fetch_data", fetch_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, LT, 11, 0, 0, 0, 32'h300, 5, 1);
        @(posedge clk);
        @(negedge clk);
        chk("rststall.mem11", out_result, 32'hA5A5A5A5);
        chk("rststall.fetch5", fetch_data, 32'hDEADBEEF);

        // ---------------- randomized phase ----------------
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mk[i] = 1'b0;
        m_valid = 0; m_res = 0; m_res_k = 1; m_ireg = 0; m_fetch = 0; m_fetch_k = 1;
        m_lc = 0; m_sc = 0; m_stc = 0;

        for (int it = 0; it < 400; it++) begin
            logic        v, r, acc, exp_rdy;
            logic [4:0]  t;
            int          ix, fx;
            logic [31:0] d, alu, ir;
            logic [3:0]  s;

            chk($sformatf("rnd%0d.out_valid", it), {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid && m_res_k) chk($sformatf("rnd%0d.out_result", it), out_result, m_res);
            if (m_valid) chk($sformatf("rnd%0d.out_ireg", it), out_ireg, m_ireg);
            if (m_fetch_k) chk($sformatf("rnd%0d.fetch_data", it), fetch_data, m_fetch);
            if (it % 50 == 49) chk_counters($sformatf("rnd%0d", it), m_lc, m_sc, m_stc);

            ix  = $urandom_range(0, 15);
            fx  = $urandom_range(0, 15);
            d   = $urandom;
            alu = $urandom;
            ir  = $urandom;
            if (it < 16) begin
                v = 1; t = ST; ix = it; s = 4'hF; r = 1;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0: t = LT;
                    1: t = ST;
                    2: t = 5'd0;
                    default: t = 5'd7;
                endcase
                s = 4'($urandom);
                r = ($urandom_range(0, 3) != 0);
            end
            drive(v, t, (32'($urandom_range(0, 7)) << 11) | 32'(ix), d, s, alu, ir,
                  (32'($urandom_range(0, 7)) << 11) | 32'(fx), r);
            #1;
            exp_rdy = !m_valid || r;
            chk($sformatf("rnd%0d.in_ready", it), {31'd0, in_ready}, {31'd0, exp_rdy});

            // Model step: reads see contents before this cycle's store.
            acc = v && exp_rdy;
            if (m_valid && !r) m_stc++;
            m_fetch   = mm[fx];
            m_fetch_k = mk[fx];
            if (acc) begin
                m_valid = 1;
                m_ireg  = ir;
                if (t == LT) begin
                    m_res = mm[ix]; m_res_k = mk[ix]; m_lc++;
                end else begin
                    m_res = alu; m_res_k = 1;
                end
                if (t == ST) begin
                    m_sc++;
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mm[ix][b*8 +: 8] = d[b*8 +: 8];
                    if (s == 4'hF) mk[ix] = 1'b1;
                end
            end else if (r) begin
                m_valid = 0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk_counters("final", m_lc, m_sc, m_stc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
